// File: rtl/iob_spi_flash_arb.sv
// Shares one spi_master_fl core between the cache read port and the software command port.
// One transaction at a time; all core inputs and requester outputs come straight from flops.
module iob_spi_flash_arb #(
  parameter int unsigned ADDR_W          = 24,
  parameter int unsigned DATA_W          = 32,
  parameter logic [31:0] CACHE_COMMAND   = 32'h0000_2003,
  parameter logic [31:0] CACHE_COMMANDTP = 32'h0000_0001,
  parameter int unsigned MAX_CACHE_BURST = 4,
  parameter int unsigned START_TO        = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cache_valid_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  output logic [DATA_W-1:0] cache_rdata_o,
  output logic              cache_ready_o,
  input  logic              sw_valid_i,
  input  logic [31:0]       sw_addr_i,
  input  logic [DATA_W-1:0] sw_datain_i,
  input  logic [31:0]       sw_command_i,
  input  logic [31:0]       sw_commandtp_i,
  output logic [DATA_W-1:0] sw_rdata_o,
  output logic              sw_ready_o,
  output logic              sw_err_o,
  output logic              busy_o,
  output logic              fl_valid_o,
  output logic [31:0]       fl_address_o,
  output logic [DATA_W-1:0] fl_datain_o,
  output logic [31:0]       fl_command_o,
  output logic [31:0]       fl_commandtp_o,
  input  logic              fl_tready_i,
  input  logic [DATA_W-1:0] fl_dataout_i
);

  localparam logic [3:0] MaxBurst = 4'(MAX_CACHE_BURST);
  localparam logic [7:0] StartTo  = 8'(START_TO);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_sw_q, owner_sw_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic              fl_valid_q, fl_valid_d;
  logic [31:0]       fl_address_q, fl_address_d;
  logic [DATA_W-1:0] fl_datain_q, fl_datain_d;
  logic [31:0]       fl_command_q, fl_command_d;
  logic [31:0]       fl_commandtp_q, fl_commandtp_d;
  logic              cache_ready_q, cache_ready_d;
  logic [DATA_W-1:0] cache_rdata_q, cache_rdata_d;
  logic              sw_ready_q, sw_ready_d;
  logic [DATA_W-1:0] sw_rdata_q, sw_rdata_d;
  logic              sw_err_q, sw_err_d;
  logic              busy_q, busy_d;

  logic              sw_win;
  logic              resp_go;
  logic              resp_to;
  logic [DATA_W-1:0] resp_data;

  // Cache has priority unless software has watched MAX_CACHE_BURST cache grants go by.
  assign sw_win = sw_valid_i && (!cache_valid_i || (streak_q == MaxBurst));

  always_comb begin
    state_d        = state_q;
    owner_sw_d     = owner_sw_q;
    streak_d       = streak_q;
    to_cnt_d       = to_cnt_q;
    timeout_d      = timeout_q;
    fl_valid_d     = 1'b0;
    fl_address_d   = fl_address_q;
    fl_datain_d    = fl_datain_q;
    fl_command_d   = fl_command_q;
    fl_commandtp_d = fl_commandtp_q;
    cache_ready_d  = 1'b0;
    cache_rdata_d  = '0;
    sw_ready_d     = 1'b0;
    sw_rdata_d     = '0;
    sw_err_d       = sw_err_q;
    resp_go        = 1'b0;
    resp_to        = 1'b0;
    resp_data      = '0;

    unique case (state_q)
      StIdle: begin
        if (!sw_valid_i) streak_d = '0;
        if (cache_valid_i || sw_valid_i) begin
          state_d    = StIssue;
          fl_valid_d = 1'b1;
          to_cnt_d   = '0;
          timeout_d  = 1'b0;
          if (sw_win) begin
            owner_sw_d     = 1'b1;
            streak_d       = '0;
            sw_err_d       = 1'b0;
            fl_address_d   = sw_addr_i;
            fl_datain_d    = sw_datain_i;
            fl_command_d   = sw_command_i;
            fl_commandtp_d = sw_commandtp_i;
          end else begin
            owner_sw_d     = 1'b0;
            fl_address_d   = 32'(cache_addr_i);
            fl_datain_d    = '0;
            fl_command_d   = CACHE_COMMAND;
            fl_commandtp_d = CACHE_COMMANDTP;
            if (sw_valid_i && (streak_q != MaxBurst)) streak_d = streak_q + 4'd1;
          end
        end
      end
      StIssue: state_d = StWaitBusy;
      StWaitBusy: begin
        if (!fl_tready_i) begin
          state_d = StWaitDone;
        end else if (to_cnt_q == StartTo) begin
          // Core never acknowledged the start: answer with zero data and flag it.
          state_d   = StResp;
          timeout_d = 1'b1;
          resp_go   = 1'b1;
          resp_to   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      StWaitDone: begin
        if (fl_tready_i) begin
          state_d   = StResp;
          resp_go   = 1'b1;
          resp_data = fl_dataout_i;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (resp_go) begin
      if (owner_sw_q) begin
        sw_ready_d = 1'b1;
        sw_rdata_d = resp_data;
        if (resp_to) sw_err_d = 1'b1;
      end else begin
        cache_ready_d = 1'b1;
        cache_rdata_d = resp_data;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q        <= StIdle;
      owner_sw_q     <= 1'b0;
      streak_q       <= '0;
      to_cnt_q       <= '0;
      timeout_q      <= 1'b0;
      fl_valid_q     <= 1'b0;
      fl_address_q   <= '0;
      fl_datain_q    <= '0;
      fl_command_q   <= '0;
      fl_commandtp_q <= '0;
      cache_ready_q  <= 1'b0;
      cache_rdata_q  <= '0;
      sw_ready_q     <= 1'b0;
      sw_rdata_q     <= '0;
      sw_err_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_sw_q     <= owner_sw_d;
      streak_q       <= streak_d;
      to_cnt_q       <= to_cnt_d;
      timeout_q      <= timeout_d;
      fl_valid_q     <= fl_valid_d;
      fl_address_q   <= fl_address_d;
      fl_datain_q    <= fl_datain_d;
      fl_command_q   <= fl_command_d;
      fl_commandtp_q <= fl_commandtp_d;
      cache_ready_q  <= cache_ready_d;
      cache_rdata_q  <= cache_rdata_d;
      sw_ready_q     <= sw_ready_d;
      sw_rdata_q     <= sw_rdata_d;
      sw_err_q       <= sw_err_d;
      busy_q         <= busy_d;
    end
  end

  assign fl_valid_o     = fl_valid_q;
  assign fl_address_o   = fl_address_q;
  assign fl_datain_o    = fl_datain_q;
  assign fl_command_o   = fl_command_q;
  assign fl_commandtp_o = fl_commandtp_q;
  assign cache_ready_o  = cache_ready_q;
  assign cache_rdata_o  = cache_rdata_q;
  assign sw_ready_o     = sw_ready_q;
  assign sw_rdata_o     = sw_rdata_q;
  assign sw_err_o       = sw_err_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_iob_spi_flash_arb.sv
// Directed bench for iob_spi_flash_arb with a small behavioural flash core model.
module tb_iob_spi_flash_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cache_valid;
  logic [23:0] cache_addr;
  logic [31:0] cache_rdata;
  logic        cache_ready;
  logic        sw_valid;
  logic [31:0] sw_addr, sw_datain, sw_command, sw_commandtp;
  logic [31:0] sw_rdata;
  logic        sw_ready, sw_err, busy;
  logic        fl_valid;
  logic [31:0] fl_address, fl_datain, fl_command, fl_commandtp;
  logic        fl_tready = 1'b1;
  logic [31:0] fl_dataout = '0;

  int total = 0;
  int bad   = 0;
  int n_valid = 0, n_cready = 0, n_sready = 0;
  int cyc = 0, issue_cyc = 0, ready_cyc = 0;
  int v0, c0, s0;

  // Core model knobs, set by the stimulus before each request.
  int          busy_n = 1;
  logic [31:0] resp   = '0;
  logic        stuck  = 1'b0;
  int          cnt    = 0;

  always #5 clk = ~clk;

  iob_spi_flash_arb dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cache_valid_i  (cache_valid),
    .cache_addr_i   (cache_addr),
    .cache_rdata_o  (cache_rdata),
    .cache_ready_o  (cache_ready),
    .sw_valid_i     (sw_valid),
    .sw_addr_i      (sw_addr),
    .sw_datain_i    (sw_datain),
    .sw_command_i   (sw_command),
    .sw_commandtp_i (sw_commandtp),
    .sw_rdata_o     (sw_rdata),
    .sw_ready_o     (sw_ready),
    .sw_err_o       (sw_err),
    .busy_o         (busy),
    .fl_valid_o     (fl_valid),
    .fl_address_o   (fl_address),
    .fl_datain_o    (fl_datain),
    .fl_command_o   (fl_command),
    .fl_commandtp_o (fl_commandtp),
    .fl_tready_i    (fl_tready),
    .fl_dataout_i   (fl_dataout)
  );

  // Core: tready drops right after the valid pulse and stays low for busy_n WAIT cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt       <= 0;
      fl_tready <= 1'b1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        fl_tready  <= 1'b1;
        fl_dataout <= resp;
      end
    end else if (fl_valid && !stuck) begin
      fl_tready  <= 1'b0;
      fl_dataout <= '0;
      cnt        <= busy_n + 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fl_valid) begin
      n_valid   <= n_valid + 1;
      issue_cyc <= cyc;
    end
    if (cache_ready) n_cready <= n_cready + 1;
    if (sw_ready) n_sready <= n_sready + 1;
    if (cache_ready || sw_ready) ready_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (cache_ready || sw_ready) return;
    end
    total++;
    bad++;
    $error("FAIL %s: no ready pulse within %0d cycles, observed=0 expected=1", tag, max_cyc);
  endtask

  task automatic wait_issue(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (fl_valid) return;
    end
    total++;
    bad++;
    $error("FAIL %s: no fl_valid pulse within %0d cycles, observed=0 expected=1", tag, max_cyc);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fl_valid"}, 32'(fl_valid), 32'd0);
    check({tag, "_fl_address"}, fl_address, 32'd0);
    check({tag, "_fl_datain"}, fl_datain, 32'd0);
    check({tag, "_fl_command"}, fl_command, 32'd0);
    check({tag, "_fl_commandtp"}, fl_commandtp, 32'd0);
    check({tag, "_cache_ready"}, 32'(cache_ready), 32'd0);
    check({tag, "_sw_ready"}, 32'(sw_ready), 32'd0);
    check({tag, "_cache_rdata"}, cache_rdata, 32'd0);
    check({tag, "_sw_rdata"}, sw_rdata, 32'd0);
    check({tag, "_sw_err"}, 32'(sw_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    cache_valid  = 1'b0;
    cache_addr   = '0;
    sw_valid     = 1'b0;
    sw_addr      = '0;
    sw_datain    = '0;
    sw_command   = '0;
    sw_commandtp = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single cache read
    busy_n = 40;
    resp   = 32'hDEAD_BEEF;
    v0 = n_valid; c0 = n_cready; s0 = n_sready;
    cache_valid = 1'b1;
    cache_addr  = 24'h00ABCD;
    wait_ready("t1_ready", 100);
    check("t1_cache_ready", 32'(cache_ready), 32'd1);
    check("t1_cache_rdata", cache_rdata, 32'hDEAD_BEEF);
    check("t1_sw_ready", 32'(sw_ready), 32'd0);
    check("t1_fl_address", fl_address, 32'h0000_ABCD);
    check("t1_fl_command", fl_command, 32'h0000_2003);
    check("t1_fl_commandtp", fl_commandtp, 32'h0000_0001);
    check("t1_fl_datain", fl_datain, 32'd0);
    cache_valid = 1'b0;
    @(negedge clk);
    check("t1_latency", 32'(ready_cyc - issue_cyc), 32'd42);
    repeat (3) @(negedge clk);
    check("t1_n_valid", 32'(n_valid - v0), 32'd1);
    check("t1_n_cache_ready", 32'(n_cready - c0), 32'd1);
    check("t1_n_sw_ready", 32'(n_sready - s0), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Software write
    busy_n       = 5;
    resp         = 32'd0;
    s0           = n_sready;
    sw_addr      = 32'h0000_0100;
    sw_datain    = 32'h1234_5678;
    sw_command   = 32'h0000_2002;
    sw_commandtp = 32'h0000_0021;
    sw_valid     = 1'b1;
    wait_issue("t2_issue", 10);
    check("t2_issue_address", fl_address, 32'h0000_0100);
    check("t2_issue_datain", fl_datain, 32'h1234_5678);
    check("t2_issue_command", fl_command, 32'h0000_2002);
    check("t2_issue_commandtp", fl_commandtp, 32'h0000_0021);
    check("t2_issue_busy", 32'(busy), 32'd1);
    wait_ready("t2_ready", 50);
    check("t2_sw_ready", 32'(sw_ready), 32'd1);
    check("t2_cache_ready", 32'(cache_ready), 32'd0);
    check("t2_resp_address", fl_address, 32'h0000_0100);
    check("t2_resp_datain", fl_datain, 32'h1234_5678);
    check("t2_resp_command", fl_command, 32'h0000_2002);
    check("t2_sw_err", 32'(sw_err), 32'd0);
    sw_valid = 1'b0;
    @(negedge clk);
    check("t2_latency", 32'(ready_cyc - issue_cyc), 32'd7);
    check("t2_n_sw_ready", 32'(n_sready - s0), 32'd1);

    // Starvation guard: four cache grants, then software, then cache again
    busy_n      = 3;
    resp        = 32'h5A5A_0000;
    cache_addr  = 24'h000010;
    sw_command  = 32'h0000_209F;
    cache_valid = 1'b1;
    sw_valid    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_ready($sformatf("t3_ready%0d", i), 30);
      check($sformatf("t3_sw_grant%0d", i), 32'(sw_ready), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("t3_cache_grant%0d", i), 32'(cache_ready), (i == 4) ? 32'd0 : 32'd1);
      if (sw_ready) sw_valid = 1'b0;
      if (i == 6) cache_valid = 1'b0;
    end
    sw_valid    = 1'b0;
    cache_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Start timeout: core never drops tready
    stuck      = 1'b1;
    sw_command = 32'h0000_2005;
    sw_valid   = 1'b1;
    wait_issue("t4_issue", 10);
    wait_ready("t4_ready", 40);
    check("t4_sw_ready", 32'(sw_ready), 32'd1);
    check("t4_sw_rdata", sw_rdata, 32'd0);
    check("t4_sw_err", 32'(sw_err), 32'd1);
    check("t4_cache_ready", 32'(cache_ready), 32'd0);
    sw_valid = 1'b0;
    @(negedge clk);
    check("t4_latency", 32'(ready_cyc - issue_cyc), 32'd17);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 32'(sw_err), 32'd1);
    check("t4_busy_idle", 32'(busy), 32'd0);
    stuck    = 1'b0;
    busy_n   = 2;
    resp     = 32'hCAFE_F00D;
    sw_valid = 1'b1;
    wait_issue("t4b_issue", 10);
    check("t4b_err_cleared", 32'(sw_err), 32'd0);
    wait_ready("t4b_ready", 30);
    check("t4b_sw_rdata", sw_rdata, 32'hCAFE_F00D);
    check("t4b_sw_err", 32'(sw_err), 32'd0);
    sw_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT_DONE
    busy_n      = 30;
    resp        = 32'h0000_0077;
    cache_addr  = 24'h000200;
    cache_valid = 1'b1;
    wait_issue("t5_issue", 10);
    repeat (4) @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    rst_n       = 1'b0;
    cache_valid = 1'b0;
    c0 = n_cready; s0 = n_sready;
    @(negedge clk);
    check_idle("t5_abort");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_cache_ready", 32'(n_cready - c0), 32'd0);
    check("t5_no_sw_ready", 32'(n_sready - s0), 32'd0);
    busy_n      = 4;
    resp        = 32'h0BAD_C0DE;
    cache_addr  = 24'h000123;
    cache_valid = 1'b1;
    wait_ready("t5b_ready", 30);
    check("t5b_cache_ready", 32'(cache_ready), 32'd1);
    check("t5b_cache_rdata", cache_rdata, 32'h0BAD_C0DE);
    check("t5b_fl_address", fl_address, 32'h0000_0123);
    cache_valid = 1'b0;
    @(negedge clk);
    check("t5b_latency", 32'(ready_cyc - issue_cyc), 32'd6);
    repeat (2) @(negedge clk);

    // Simultaneous requests at streak 0
    busy_n      = 2;
    resp        = 32'h1111_2222;
    cache_addr  = 24'h000055;
    sw_addr     = 32'h0000_0400;
    sw_command  = 32'h0000_200B;
    c0 = n_cready; s0 = n_sready;
    cache_valid = 1'b1;
    sw_valid    = 1'b1;
    wait_ready("t6_first", 30);
    check("t6_first_cache", 32'(cache_ready), 32'd1);
    check("t6_first_sw", 32'(sw_ready), 32'd0);
    check("t6_first_rdata", cache_rdata, 32'h1111_2222);
    check("t6_first_sw_rdata", sw_rdata, 32'd0);
    cache_valid = 1'b0;
    wait_ready("t6_second", 30);
    check("t6_second_sw", 32'(sw_ready), 32'd1);
    check("t6_second_cache", 32'(cache_ready), 32'd0);
    check("t6_second_rdata", sw_rdata, 32'h1111_2222);
    check("t6_second_address", fl_address, 32'h0000_0400);
    sw_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_n_cache_ready", 32'(n_cready - c0), 32'd1);
    check("t6_n_sw_ready", 32'(n_sready - s0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_spi_flash_arb.md
# iob_spi_flash_arb

Arbiter and sequencer sharing the single `spi_master_fl` flash controller core between the instruction/data cache read port and the software (CSR) command port. It grants one requester at a time and drives the core's address, data, command and valid inputs from registered copies. It tracks the core's `tready` through each transaction and returns read data with a one-cycle ready pulse. It sits between the peripheral's register file and cache port on one side and the core on the other.

## Interface
- `ADDR_W`, 24: cache address width; zero-extended to 32 bits on `fl_address_o`.
- `DATA_W`, 32: data width of all data buses.
- `CACHE_COMMAND`, 32'h0000_2003: command word for cache reads. Fields: [7:0] opcode 0x03, [14:8] ndata_bits 32, [19:16] dummy 0, [29:20] frame 0, [31:30] xip 0.
- `CACHE_COMMANDTP`, 32'h0000_0001: command-type word for cache reads (commtype 1, SPI mode 0, no DTR, 3-byte address).
- `MAX_CACHE_BURST`, 4: maximum consecutive cache grants while a software request waits (1..15).
- `START_TO`, 15: cycles allowed for `fl_tready_i` to fall after issue (1..255).

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `cache_valid_i` in 1: cache read request; held with address until `cache_ready_o`.
- `cache_addr_i` in ADDR_W: cache read address.
- `cache_rdata_o` out DATA_W: read data, valid while `cache_ready_o`=1.
- `cache_ready_o` out 1: one-cycle completion pulse.
- `sw_valid_i` in 1: software request; held with the fields below until `sw_ready_o`.
- `sw_addr_i` in 32; `sw_datain_i` in DATA_W; `sw_command_i` in 32; `sw_commandtp_i` in 32: software transaction fields.
- `sw_rdata_o` out DATA_W: result data, valid while `sw_ready_o`=1.
- `sw_ready_o` out 1: one-cycle completion pulse.
- `sw_err_o` out 1: start-timeout flag, sticky until the next software grant.
- `busy_o` out 1: high in every state except IDLE.
- `fl_valid_o` out 1; `fl_address_o` out 32; `fl_datain_o` out DATA_W; `fl_command_o` out 32; `fl_commandtp_o` out 32: core inputs.
- `fl_tready_i` in 1: core ready. High means idle or done.
- `fl_dataout_i` in DATA_W: core read data.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if either valid is high, register the winner's fields into the `fl_*` registers, record the owner, and go to ISSUE.
  - Cache grant uses `{0, cache_addr_i}`, `fl_datain_o`=0, `CACHE_COMMAND` and `CACHE_COMMANDTP`.
- Arbitration: cache wins, except when `sw_valid_i`=1 and `streak`==`MAX_CACHE_BURST`; then software wins.
- `streak` (4 bits):
  - increments on a cache grant while `sw_valid_i`=1;
  - clears on a software grant, and in any IDLE cycle with `sw_valid_i`=0;
  - saturates at `MAX_CACHE_BURST`.
- ISSUE: `fl_valid_o`=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: when `fl_tready_i`=0, go to WAIT_DONE. Otherwise increment `to_cnt`; at `to_cnt`==`START_TO`, set a timeout flag and go to RESP.
- WAIT_DONE: when `fl_tready_i`=1, capture `fl_dataout_i` into `rdata_q` and go to RESP. There is no timeout in this state.
- RESP: pulse the owner's ready for one cycle and drive `rdata_q` (0 on timeout) on the owner's rdata. On timeout with owner software, set `sw_err_o`. Go to IDLE.
- The non-owner's ready and rdata stay 0 throughout. `fl_*` fields hold stable from ISSUE through RESP.
- A requester that keeps valid high after its ready pulse is treated as a new request in the following IDLE cycle.

## Timing
- Reset (`rst_n_i`=0 at a rising edge): state IDLE, `streak`=0, `to_cnt`=0. All outputs 0: `fl_valid_o`, `fl_*` fields, both ready and rdata outputs, `sw_err_o`, `busy_o`.
- Reset mid-transaction aborts with no ready pulse. The core is reset separately.
- Grant at IDLE edge t: ISSUE in cycle t+1 (`fl_valid_o`=1), WAIT_BUSY from t+2.
- Minimum latency, with the core dropping `tready` one cycle after valid and a core transaction of N busy cycles: ready at t+N+3 relative to the sampling cycle.
- Timeout response: ready `START_TO`+2 cycles after ISSUE.
- At most one transaction outstanding. Back-to-back grants are separated by one IDLE cycle.
- Simultaneous requests in IDLE: resolved by the arbitration rule in the same cycle. No combinational path from any input to any output.

## Test plan
- Single cache read, address 0x00ABCD, core model busy 40 cycles returning 0xDEADBEEF -> exactly one `fl_valid_o` pulse.
  - Required: `fl_address_o`=0x0000ABCD, `fl_command_o`=0x00002003; one `cache_ready_o` pulse with rdata 0xDEADBEEF; `sw_ready_o` stays 0.
- Software write: command 0x00002002, datain 0x12345678, address 0x100 -> `fl_*` fields match the inputs exactly from ISSUE to RESP; `sw_ready_o` pulses once; `sw_err_o`=0.
- Starvation: cache valid held continuously, software valid raised -> exactly 4 cache grants, then the software grant, then cache grants resume.
- Start timeout: core holds `tready`=1 -> `sw_ready_o` 17 cycles after ISSUE with rdata 0 and `sw_err_o`=1; `sw_err_o` clears on the next software grant.
- Reset asserted during WAIT_DONE -> next cycle: state IDLE, all outputs 0, no ready pulse. A subsequent request completes normally.
- Simultaneous cache and software requests at `streak`=0 -> cache is granted first, software second, each with a single ready pulse.
